sparce_skip_sched: RTL and testbench
====================================

# sparce_skip_sched

Sequencing controller for the SparCE sparsity-skip path. It watches fetched PCs and looks each one up in the SASA table. On a hit, it checks the sparsity state of the named source registers. When the skip condition holds, it drives `sparce_target`/`skipping` toward fetch and hazard until the pipeline accepts the redirect. It sits between fetch, the SASA table, the sparsity register file (SPRF) and hazard control, and owns the SparCE skip decision.

## Interface
Parameters:
- `EVAL_RETRY_MAX`, default 4: maximum EVAL cycles spent waiting out writeback conflicts before the skip is abandoned.
- `CNT_W`, default 16: width of the skip statistics counter.

Ports:
- `CLK`  in  1  clock, rising edge.
- `nRST`  in  1  asynchronous active-low reset.
- `pc`  in  32  fetch PC.
- `pc_valid`  in  1  one-cycle pulse: new PC presented on `pc`.
- `flush`  in  1  pipeline flush (branch, exception).
- `if_ex_enable`  in  1  pipeline advancing from IF to EX.
- `wb_en`  in  1  writeback enable.
- `rd`  in  5  writeback destination register.
- `sasa_req`  out  1  SASA lookup request.
- `sasa_addr_q`  out  32  PC being looked up.
- `sasa_ack`  in  1  lookup response valid.
- `sasa_hit`  in  1  entry found.
- `sasa_target`  in  32  skip target PC.
- `sasa_rs1`  in  5  first condition register.
- `sasa_rs2`  in  5  second condition register.
- `sasa_cond`  in  2  condition code, `sasa_cond_t`.
- `sprf_rs1`  out  5  SPRF read index 1.
- `sprf_rs2`  out  5  SPRF read index 2.
- `sprf_sparse1`  in  1  register `sprf_rs1` is zero (combinational, same cycle).
- `sprf_sparse2`  in  1  register `sprf_rs2` is zero (combinational, same cycle).
- `sparce_target`  out  32  redirect PC.
- `skipping`  out  1  redirect request.
- `skip_count`  out  `CNT_W`  skips committed, saturating.

## Operation
- States: IDLE, LOOKUP, EVAL, REDIRECT (`sparce_state_t`).
- IDLE:
  - `pc_valid` latches `pc` into `pc_q` and moves to LOOKUP.
  - `sasa_ack` is ignored.
- LOOKUP:
  - `sasa_req`=1 and `sasa_addr_q`=`pc_q` until `sasa_ack`.
  - Ack with miss goes to IDLE.
  - Ack with hit latches target, rs1, rs2 and cond, clears `retry_cnt`, and moves to EVAL.
- EVAL:
  - `sprf_rs1`/`sprf_rs2` are driven from the latched rs1/rs2.
  - A conflict exists when `wb_en` is set and `rd`≠0 equals either latched rs.
  - Conflict with `retry_cnt` < `EVAL_RETRY_MAX`-1: increment `retry_cnt` and stay in EVAL.
  - Conflict otherwise: go to IDLE (abandon).
  - No conflict with the condition met: go to REDIRECT.
  - No conflict with the condition not met: go to IDLE.
- Conditions (`sasa_cond`): 00 = rs1 sparse; 01 = rs2 sparse; 10 = rs1 OR rs2 sparse; 11 = rs1 AND rs2 sparse.
- REDIRECT:
  - `skipping`=1 and `sparce_target`=latched target.
  - State is held until a cycle with `if_ex_enable`=1; the controller then goes to IDLE.
  - `skip_count` increments once on entry, saturating at all-ones.
- `pc_valid` in LOOKUP or EVAL aborts the current check: latch the new `pc` and go to LOOKUP. `pc_valid` in REDIRECT is ignored.
- `flush` in any state forces IDLE on the next edge and overrides every other transition. `skip_count` is kept.
- Reset values:
  - state IDLE.
  - `sasa_req`, `skipping` = 0.
  - `sasa_addr_q`, `sparce_target` = 0.
  - `sprf_rs1`, `sprf_rs2` = 0.
  - `skip_count` = 0.
- Reset mid-operation drops any pending request or redirect immediately (asynchronous).

## Timing
- All outputs are registered or decoded from registered state. There is no input-to-output combinational path except `sprf_rs*` ← latched state.
- `pc_valid` at cycle 0 gives `sasa_req`=1 in cycle 1.
- A same-cycle ack in cycle 1 gives EVAL in cycle 2 and `skipping`=1 in cycle 3. Minimum latency is 3 cycles.
- `skipping` drops the cycle after the first `if_ex_enable`=1 seen during REDIRECT. It is asserted for at least 1 cycle.
- Simultaneous events:
  - `flush` and `pc_valid` in the same cycle: go to IDLE; the new PC is not looked up.
  - `sasa_ack` and `pc_valid` in LOOKUP: `pc_valid` wins and the ack is discarded.
- `skip_count` updates on the edge entering REDIRECT.

## Structure
- `sparce_pkg` holds `sasa_cond_t` (RS1, RS2, EITHER, BOTH), `sparce_state_t`, and `SPARCE_REG_W`=5.
- `word_t` comes from `rv32i_types_pkg`.
- One combinational sub-module, `sparce_cond_eval`, takes cond, sparse1 and sparse2 and returns met.

## Test plan
- Hit, condition met: `pc_valid` with pc=0x100; ack at cycle 1 with hit, target=0x140, cond=00, rs1=5; `sprf_sparse1`=1; `if_ex_enable`=1 → `skipping`=1 with `sparce_target`=0x140 in cycle 3 only, `skip_count`=1.
- Miss, and condition not met: ack with miss → back to IDLE, `skipping` never set. Hit with cond=11 and sparse1=1, sparse2=0 → no skip, count unchanged.
- Writeback conflict: hit with rs1=7, `wb_en`=1 and `rd`=7 for 2 cycles, then clear with sparse1=1 → `skipping` asserts 2 cycles late. Conflict held for 4 cycles → abandon, no skip.
- Stall and flush:
  - Stalled redirect: `if_ex_enable`=0 for 3 cycles in REDIRECT → `skipping` held 4 cycles, `sparce_target` stable, count +1 only.
  - Flush and abort: `flush` during REDIRECT → `skipping`=0 on the next cycle. `pc_valid`=0x200 during LOOKUP of 0x100 → `sasa_addr_q` becomes 0x200 and the stale ack is discarded.
- Saturation and reset: preload `skip_count` to 0xFFFE, perform 3 skips → reads 0xFFFF. `nRST` low mid-LOOKUP → all outputs 0 immediately.

Source files
------------

// File: rtl/rv32i_types_pkg.sv
// Shared RV32I scalar types used across the core.
// No logic, types only.
// No flow control.
package rv32i_types_pkg;
  typedef logic [31:0] word_t;
endpackage

// File: rtl/sparce_pkg.sv
// Types and constants for the SparCE sparsity-skip path.
// No logic, types only.
// No flow control.
package sparce_pkg;
  localparam int SPARCE_REG_W = 5;

  typedef enum logic [1:0] {
    RS1    = 2'b00,
    RS2    = 2'b01,
    EITHER = 2'b10,
    BOTH   = 2'b11
  } sasa_cond_t;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    LOOKUP   = 2'b01,
    EVAL     = 2'b10,
    REDIRECT = 2'b11
  } sparce_state_t;
endpackage

// File: rtl/sparce_cond_eval.sv
// Decides whether a SASA skip condition holds given the two sparsity flags.
// Latency: purely combinational.
// No flow control.
module sparce_cond_eval
  import sparce_pkg::*;
(
  input  logic [1:0] i_cond,
  input  logic       i_sparse1,
  input  logic       i_sparse2,
  output logic       o_met
);

  sasa_cond_t w_cond;
  assign w_cond = sasa_cond_t'(i_cond);

  // Map condition code onto the sparsity flags
  always_comb begin
    o_met = 1'b0;
    case (w_cond)
      RS1:     o_met = i_sparse1;
      RS2:     o_met = i_sparse2;
      EITHER:  o_met = i_sparse1 | i_sparse2;
      BOTH:    o_met = i_sparse1 & i_sparse2;
      default: o_met = 1'b0;
    endcase
  end

endmodule

// File: rtl/sparce_skip_sched.sv
// SparCE skip sequencer: PC -> SASA lookup -> SPRF condition check -> redirect.
// Latency: pc_valid to skipping is 3 cycles minimum (plus writeback-conflict retries).
// Backpressure: redirect is held until if_ex_enable; LOOKUP waits for sasa_ack.
module sparce_skip_sched
  import sparce_pkg::*;
  import rv32i_types_pkg::*;
#(
  parameter int EVAL_RETRY_MAX = 4,
  parameter int CNT_W          = 16
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic [31:0]             pc,
  input  logic                    pc_valid,
  input  logic                    flush,
  input  logic                    if_ex_enable,
  input  logic                    wb_en,
  input  logic [SPARCE_REG_W-1:0] rd,
  output logic                    sasa_req,
  output logic [31:0]             sasa_addr_q,
  input  logic                    sasa_ack,
  input  logic                    sasa_hit,
  input  logic [31:0]             sasa_target,
  input  logic [SPARCE_REG_W-1:0] sasa_rs1,
  input  logic [SPARCE_REG_W-1:0] sasa_rs2,
  input  logic [1:0]              sasa_cond,
  output logic [SPARCE_REG_W-1:0] sprf_rs1,
  output logic [SPARCE_REG_W-1:0] sprf_rs2,
  input  logic                    sprf_sparse1,
  input  logic                    sprf_sparse2,
  output logic [31:0]             sparce_target,
  output logic                    skipping,
  output logic [CNT_W-1:0]        skip_count
);

  localparam int RETRY_W = (EVAL_RETRY_MAX > 1) ? $clog2(EVAL_RETRY_MAX) : 1;
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(EVAL_RETRY_MAX - 1);

  sparce_state_t             r_state;
  word_t                     r_pc_q;
  word_t                     r_target;
  logic [SPARCE_REG_W-1:0]   r_rs1;
  logic [SPARCE_REG_W-1:0]   r_rs2;
  sasa_cond_t                r_cond;
  logic [RETRY_W-1:0]        r_retry;
  logic                      r_sasa_req;
  logic                      r_skipping;
  logic [CNT_W-1:0]          r_skip_count;

  logic                      w_conflict;
  logic                      w_met;

  // A pending writeback to either condition register makes the SPRF flags stale
  assign w_conflict = wb_en && (rd != '0) && ((rd == r_rs1) || (rd == r_rs2));

  sparce_cond_eval u_cond_eval (
    .i_cond    (r_cond),
    .i_sparse1 (sprf_sparse1),
    .i_sparse2 (sprf_sparse2),
    .o_met     (w_met)
  );

  // Skip sequencer; flush beats everything, pc_valid restarts an unfinished check
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state      <= IDLE;
      r_pc_q       <= '0;
      r_target     <= '0;
      r_rs1        <= '0;
      r_rs2        <= '0;
      r_cond       <= RS1;
      r_retry      <= '0;
      r_sasa_req   <= 1'b0;
      r_skipping   <= 1'b0;
      r_skip_count <= '0;
    end else if (flush) begin
      r_state    <= IDLE;
      r_sasa_req <= 1'b0;
      r_skipping <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (pc_valid) begin
            r_pc_q     <= pc;
            r_state    <= LOOKUP;
            r_sasa_req <= 1'b1;
          end
        end
        LOOKUP: begin
          if (pc_valid) begin
            // a same-cycle ack belongs to the old PC and is dropped
            r_pc_q <= pc;
          end else if (sasa_ack) begin
            r_sasa_req <= 1'b0;
            if (sasa_hit) begin
              r_target <= sasa_target;
              r_rs1    <= sasa_rs1;
              r_rs2    <= sasa_rs2;
              r_cond   <= sasa_cond_t'(sasa_cond);
              r_retry  <= '0;
              r_state  <= EVAL;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        EVAL: begin
          if (pc_valid) begin
            r_pc_q     <= pc;
            r_state    <= LOOKUP;
            r_sasa_req <= 1'b1;
          end else if (w_conflict) begin
            if (r_retry < RETRY_LAST) r_retry <= r_retry + 1'b1;
            else                      r_state <= IDLE;
          end else if (w_met) begin
            r_state      <= REDIRECT;
            r_skipping   <= 1'b1;
            r_skip_count <= (r_skip_count == '1) ? r_skip_count : r_skip_count + 1'b1;
          end else begin
            r_state <= IDLE;
          end
        end
        REDIRECT: begin
          if (if_ex_enable) begin
            r_state    <= IDLE;
            r_skipping <= 1'b0;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_sasa_req <= 1'b0;
          r_skipping <= 1'b0;
        end
      endcase
    end
  end

  assign sasa_req      = r_sasa_req;
  assign sasa_addr_q   = r_pc_q;
  assign sprf_rs1      = r_rs1;
  assign sprf_rs2      = r_rs2;
  assign skipping      = r_skipping;
  assign sparce_target = r_skipping ? r_target : '0;
  assign skip_count    = r_skip_count;

endmodule

// File: tb/tb_sparce_skip_sched.sv
// Directed bench for sparce_skip_sched with a redirect scoreboard.
// Stimulus queues expected redirects; a negedge monitor matches them.
// Counter width reduced so saturation is reachable.
module tb_sparce_skip_sched;

  localparam int CNT_W   = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [31:0] pc;
  logic        pc_valid, flush, if_ex_enable, wb_en;
  logic [4:0]  rd;
  logic        sasa_req;
  logic [31:0] sasa_addr_q;
  logic        sasa_ack, sasa_hit;
  logic [31:0] sasa_target;
  logic [4:0]  sasa_rs1, sasa_rs2;
  logic [1:0]  sasa_cond;
  logic [4:0]  sprf_rs1, sprf_rs2;
  logic        sprf_sparse1, sprf_sparse2;
  logic [31:0] sparce_target;
  logic        skipping;
  logic [CNT_W-1:0] skip_count;

  sparce_skip_sched #(.EVAL_RETRY_MAX(4), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .nRST(nRST), .pc(pc), .pc_valid(pc_valid), .flush(flush),
    .if_ex_enable(if_ex_enable), .wb_en(wb_en), .rd(rd),
    .sasa_req(sasa_req), .sasa_addr_q(sasa_addr_q), .sasa_ack(sasa_ack),
    .sasa_hit(sasa_hit), .sasa_target(sasa_target), .sasa_rs1(sasa_rs1),
    .sasa_rs2(sasa_rs2), .sasa_cond(sasa_cond), .sprf_rs1(sprf_rs1),
    .sprf_rs2(sprf_rs2), .sprf_sparse1(sprf_sparse1), .sprf_sparse2(sprf_sparse2),
    .sparce_target(sparce_target), .skipping(skipping), .skip_count(skip_count)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc++;

  typedef struct {
    logic [31:0] tgt;
    int          cnt;
    int          start;
    int          dur;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // count model saturates like the hardware counter should
  task automatic expect_skip(input logic [31:0] tgt, input int start, input int dur);
    exp_t e;
    exp_count = (exp_count == CNT_MAX) ? CNT_MAX : exp_count + 1;
    e.tgt = tgt; e.cnt = exp_count; e.start = start; e.dur = dur;
    exp_q.push_back(e);
  endtask

  // pc_valid in cycle t0, ack in t0+1; returns at start of t0+2 (first EVAL cycle)
  task automatic lookup(input logic [31:0] p, input logic hit, input logic [31:0] tgt,
                        input logic [4:0] a, input logic [4:0] b, input logic [1:0] c,
                        output int t0);
    t0 = cyc;
    pc = p; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0;
    chk("lookup_req", {31'd0, sasa_req}, 32'd1);
    chk("lookup_addr", sasa_addr_q, p);
    sasa_ack = 1'b1; sasa_hit = hit; sasa_target = tgt;
    sasa_rs1 = a; sasa_rs2 = b; sasa_cond = c;
    tick();
    sasa_ack = 1'b0; sasa_hit = 1'b0;
    if (hit) begin
      chk("eval_rs1", {27'd0, sprf_rs1}, {27'd0, a});
      chk("eval_rs2", {27'd0, sprf_rs2}, {27'd0, b});
    end else begin
      chk("miss_req", {31'd0, sasa_req}, 32'd0);
    end
  endtask

  // Monitor: every redirect pulse must match the head of the scoreboard
  logic prev_skip = 1'b0;
  logic active = 1'b0;
  int   dur_seen = 0;
  exp_t cur;
  always @(negedge CLK) begin
    if (skipping && !prev_skip) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_skip: skipping=1 target 0x%0h at cycle %0d, none expected", sparce_target, cyc);
        active = 1'b0;
      end else begin
        cur = exp_q.pop_front();
        chk("skip_target", sparce_target, cur.tgt);
        chk("skip_count", 32'(skip_count), cur.cnt);
        chk("skip_start_cycle", cyc, cur.start);
        active = 1'b1;
        dur_seen = 1;
      end
    end else if (skipping && prev_skip) begin
      dur_seen++;
      if (active) chk("skip_target_stable", sparce_target, cur.tgt);
    end else if (!skipping && prev_skip && active) begin
      chk("skip_duration", dur_seen, cur.dur);
      active = 1'b0;
    end
    prev_skip = skipping;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    nRST = 1'b0; pc = '0; pc_valid = 0; flush = 0; if_ex_enable = 1'b1;
    wb_en = 0; rd = '0; sasa_ack = 0; sasa_hit = 0; sasa_target = '0;
    sasa_rs1 = '0; sasa_rs2 = '0; sasa_cond = '0; sprf_sparse1 = 0; sprf_sparse2 = 0;
    tick(); tick();
    chk("rst_sasa_req", {31'd0, sasa_req}, 32'd0);
    chk("rst_skipping", {31'd0, skipping}, 32'd0);
    chk("rst_sasa_addr_q", sasa_addr_q, 32'd0);
    chk("rst_sparce_target", sparce_target, 32'd0);
    chk("rst_sprf_rs1", {27'd0, sprf_rs1}, 32'd0);
    chk("rst_sprf_rs2", {27'd0, sprf_rs2}, 32'd0);
    chk("rst_skip_count", 32'(skip_count), 32'd0);
    nRST = 1'b1;
    tick(); tick();

    // hit, condition met, minimum latency
    sprf_sparse1 = 1'b1;
    lookup(32'h100, 1'b1, 32'h140, 5'd5, 5'd0, 2'b00, t0);
    expect_skip(32'h140, t0 + 3, 1);
    repeat (3) tick();

    // miss
    lookup(32'h300, 1'b0, 32'h0, 5'd0, 5'd0, 2'b00, t0);
    repeat (3) tick();

    // BOTH with only rs1 sparse: no skip
    sprf_sparse1 = 1'b1; sprf_sparse2 = 1'b0;
    lookup(32'h104, 1'b1, 32'h1A0, 5'd1, 5'd2, 2'b11, t0);
    repeat (3) tick();
    chk("cond_both_count", 32'(skip_count), exp_count);

    // writeback conflict for 2 cycles: skip 2 cycles late
    lookup(32'h108, 1'b1, 32'h180, 5'd7, 5'd0, 2'b00, t0);
    wb_en = 1'b1; rd = 5'd7;
    tick(); tick();
    wb_en = 1'b0; rd = '0;
    expect_skip(32'h180, t0 + 5, 1);
    repeat (4) tick();

    // conflict on rs2 for 4 cycles: abandon
    sprf_sparse1 = 1'b0; sprf_sparse2 = 1'b1;
    lookup(32'h10C, 1'b1, 32'h1B0, 5'd3, 5'd9, 2'b01, t0);
    wb_en = 1'b1; rd = 5'd9;
    repeat (4) tick();
    wb_en = 1'b0; rd = '0;
    repeat (4) tick();
    chk("abandon_count", 32'(skip_count), exp_count);

    // stalled redirect, EITHER condition via rs2
    lookup(32'h110, 1'b1, 32'h1C0, 5'd4, 5'd6, 2'b10, t0);
    if_ex_enable = 1'b0;
    expect_skip(32'h1C0, t0 + 3, 4);
    repeat (4) tick();
    if_ex_enable = 1'b1;
    repeat (3) tick();

    // flush during redirect
    sprf_sparse1 = 1'b1; sprf_sparse2 = 1'b0;
    lookup(32'h114, 1'b1, 32'h240, 5'd5, 5'd0, 2'b00, t0);
    if_ex_enable = 1'b0;
    expect_skip(32'h240, t0 + 3, 1);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0; if_ex_enable = 1'b1;
    tick();

    // flush and pc_valid together: no lookup
    flush = 1'b1; pc_valid = 1'b1; pc = 32'h500;
    tick();
    flush = 1'b0; pc_valid = 1'b0;
    chk("flush_pcvalid_req", {31'd0, sasa_req}, 32'd0);
    tick();

    // abort: new PC during LOOKUP, stale ack dropped
    t0 = cyc;
    pc = 32'h100; pc_valid = 1'b1;
    tick();
    chk("abort_addr_old", sasa_addr_q, 32'h100);
    pc = 32'h200; pc_valid = 1'b1;
    sasa_ack = 1'b1; sasa_hit = 1'b1; sasa_target = 32'h999; sasa_rs1 = 5'd5; sasa_cond = 2'b00;
    tick();
    pc_valid = 1'b0; sasa_ack = 1'b0; sasa_hit = 1'b0;
    chk("abort_addr_new", sasa_addr_q, 32'h200);
    chk("abort_req", {31'd0, sasa_req}, 32'd1);
    tick();
    sasa_ack = 1'b1; sasa_hit = 1'b1; sasa_target = 32'h280;
    tick();
    sasa_ack = 1'b0; sasa_hit = 1'b0;
    expect_skip(32'h280, t0 + 5, 1);
    repeat (4) tick();

    // saturation
    for (int i = 0; i < 3; i++) begin
      lookup(32'h600 + 32'(i * 4), 1'b1, 32'h300 + 32'(i * 4), 5'd5, 5'd0, 2'b00, t0);
      expect_skip(32'h300 + 32'(i * 4), t0 + 3, 1);
      repeat (3) tick();
    end
    chk("sat_count", 32'(skip_count), CNT_MAX);

    // asynchronous reset mid-LOOKUP
    pc = 32'h400; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0;
    chk("pre_rst_req", {31'd0, sasa_req}, 32'd1);
    #2 nRST = 1'b0;
    #1;
    chk("arst_sasa_req", {31'd0, sasa_req}, 32'd0);
    chk("arst_sasa_addr_q", sasa_addr_q, 32'd0);
    chk("arst_skipping", {31'd0, skipping}, 32'd0);
    chk("arst_skip_count", 32'(skip_count), 32'd0);
    tick();
    nRST = 1'b1;
    repeat (3) tick();

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
